// File: rtl/valu_result_buffer.sv
// In-order result buffer behind the vector logic pipeline: absorbs one result per cycle,
// drains vector results to the VRF port and scalar moves to the scalar port.
module valu_result_buffer #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int XLEN         = 32,
  parameter int DEPTH        = 16,
  parameter int PIPE_LATENCY = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_vec,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic                    in_sca,
  input  logic                    in_mask,
  input  logic                    in_w_reg,
  output logic                    vrf_valid,
  input  logic                    vrf_ready,
  output logic [ADDR_WIDTH-1:0]   vrf_addr,
  output logic [DATA_WIDTH-1:0]   vrf_data,
  output logic                    vrf_mask,
  output logic                    vrf_w_reg,
  output logic                    sca_valid,
  input  logic                    sca_ready,
  output logic [XLEN-1:0]         sca_data,
  output logic                    issue_stall,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] addr;
    logic                  sca;
    logic                  mask;
    logic                  w_reg;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        head;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          nonempty, full, push, pop;

  assign head     = mem[rd_ptr];
  assign nonempty = (cnt != '0);
  assign full     = (cnt == CW'(DEPTH));

  assign vrf_valid = nonempty & ~head.sca;
  assign sca_valid = nonempty &  head.sca;
  assign vrf_addr  = head.addr;
  assign vrf_data  = head.data;
  assign vrf_mask  = head.mask;
  assign vrf_w_reg = head.w_reg;
  assign sca_data  = head.data[XLEN-1:0];

  // A pop frees a slot in the same cycle, so a full buffer can still accept.
  assign pop  = (vrf_valid & vrf_ready) | (sca_valid & sca_ready);
  assign push = in_valid & (~full | pop);

  // Threshold leaves room for every op already in flight in the upstream pipe.
  assign issue_stall = (cnt >= CW'(DEPTH - PIPE_LATENCY));
  assign count       = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
      if (in_valid && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= '{data: in_vec, addr: in_addr, sca: in_sca,
                                       mask: in_mask, w_reg: in_w_reg};
  end
endmodule

// File: tb/tb_valu_result_buffer.sv
// Directed bench for valu_result_buffer: vector table for simple flows, hand sequences
// for fill/stall, full push+pop, overflow and mid-run reset.
module tb_valu_result_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sca, in_mask, in_w_reg;
  logic [63:0] in_vec;
  logic [31:0] in_addr;
  logic        vrf_valid, vrf_ready, vrf_mask, vrf_w_reg;
  logic [31:0] vrf_addr;
  logic [63:0] vrf_data;
  logic        sca_valid, sca_ready;
  logic [31:0] sca_data;
  logic        issue_stall, overflow;
  logic [4:0]  count;

  int n_chk = 0;
  int n_fail = 0;

  valu_result_buffer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_vec(in_vec), .in_addr(in_addr),
    .in_sca(in_sca), .in_mask(in_mask), .in_w_reg(in_w_reg),
    .vrf_valid(vrf_valid), .vrf_ready(vrf_ready), .vrf_addr(vrf_addr),
    .vrf_data(vrf_data), .vrf_mask(vrf_mask), .vrf_w_reg(vrf_w_reg),
    .sca_valid(sca_valid), .sca_ready(sca_ready), .sca_data(sca_data),
    .issue_stall(issue_stall), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;  logic [63:0] d; logic [31:0] a;
    logic        s;  logic m; logic w; logic vr; logic sr;
    int          cnt; logic ev; logic es;
    logic [63:0] ed; logic [31:0] ea; logic em; logic ew;
  } row_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_vec(input logic [63:0] d, input logic [31:0] a);
    in_valid = 1'b1; in_vec = d; in_addr = a; in_sca = 1'b0; in_mask = 1'b0; in_w_reg = 1'b0;
    cyc();
    in_valid = 1'b0;
  endtask

  row_t tbl [7];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_vec = '0; in_addr = '0; in_sca = 1'b0;
    in_mask = 1'b0; in_w_reg = 1'b0; vrf_ready = 1'b0; sca_ready = 1'b0;
    cyc(); cyc();
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_vrf_valid", 64'(vrf_valid), 64'd0);
    chk("reset_sca_valid", 64'(sca_valid), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    chk("reset_stall", 64'(issue_stall), 64'd0);
    rst = 1'b0;
    cyc();

    // v d a s m w vr sr | cnt ev es ed ea em ew  (outputs after the edge)
    tbl[0] = '{1'b1, 64'hDEADBEEF00000001, 32'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0,
               1, 1'b1, 1'b0, 64'hDEADBEEF00000001, 32'h40, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 64'h123456789ABCDEF0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0,
               1, 1'b0, 1'b1, 64'h9ABCDEF0, 32'h0, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 64'h80AA, 32'h80, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               2, 1'b0, 1'b1, 64'h9ABCDEF0, 32'h0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               2, 1'b0, 1'b1, 64'h9ABCDEF0, 32'h0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
               1, 1'b1, 1'b0, 64'h80AA, 32'h80, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
               0, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0};

    for (int i = 0; i < 7; i++) begin
      in_valid = tbl[i].v; in_vec = tbl[i].d; in_addr = tbl[i].a; in_sca = tbl[i].s;
      in_mask = tbl[i].m; in_w_reg = tbl[i].w; vrf_ready = tbl[i].vr; sca_ready = tbl[i].sr;
      cyc();
      chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("tbl%0d_vrf_valid", i), 64'(vrf_valid), 64'(tbl[i].ev));
      chk($sformatf("tbl%0d_sca_valid", i), 64'(sca_valid), 64'(tbl[i].es));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_vrf_data", i), vrf_data, tbl[i].ed);
        chk($sformatf("tbl%0d_vrf_addr", i), 64'(vrf_addr), 64'(tbl[i].ea));
        chk($sformatf("tbl%0d_vrf_mask", i), 64'(vrf_mask), 64'(tbl[i].em));
        chk($sformatf("tbl%0d_vrf_w_reg", i), 64'(vrf_w_reg), 64'(tbl[i].ew));
      end
      if (tbl[i].es) chk($sformatf("tbl%0d_sca_data", i), 64'(sca_data), tbl[i].ed);
    end
    in_valid = 1'b0; in_sca = 1'b0; in_mask = 1'b0; in_w_reg = 1'b0; sca_ready = 1'b0;

    // Fill and stall, then drain in order
    vrf_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      push_vec(64'h1000 + 64'(k - 1), 32'(k - 1));
      chk($sformatf("fill%0d_count", k), 64'(count), 64'(k));
      chk($sformatf("fill%0d_stall", k), 64'(issue_stall), 64'(k >= 10));
    end
    chk("fill_overflow", 64'(overflow), 64'd0);
    vrf_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("drain%0d_data", j), vrf_data, 64'h1000 + 64'(j));
      cyc();
      chk($sformatf("drain%0d_count", j), 64'(count), 64'(15 - j));
      chk($sformatf("drain%0d_stall", j), 64'(issue_stall), 64'((15 - j) >= 10));
    end

    // Full push+pop in the same cycle
    vrf_ready = 1'b0;
    for (int k = 0; k < 16; k++) push_vec(64'h2000 + 64'(k), 32'(k));
    vrf_ready = 1'b1;
    push_vec(64'h2FFF, 32'hFF);
    chk("fullpp_count", 64'(count), 64'd16);
    chk("fullpp_overflow", 64'(overflow), 64'd0);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("fullpp%0d_data", j), vrf_data, (j == 15) ? 64'h2FFF : 64'h2001 + 64'(j));
      cyc();
    end
    chk("fullpp_empty", 64'(count), 64'd0);

    // Overflow: 17th push dropped
    vrf_ready = 1'b0;
    for (int k = 0; k < 16; k++) push_vec(64'h3000 + 64'(k), 32'(k));
    push_vec(64'hBAD, 32'hBAD);
    chk("ovf_count", 64'(count), 64'd16);
    chk("ovf_flag", 64'(overflow), 64'd1);
    cyc();
    chk("ovf_sticky", 64'(overflow), 64'd1);
    vrf_ready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("ovf%0d_data", j), vrf_data, 64'h3000 + 64'(j));
      cyc();
    end
    chk("ovf_empty_count", 64'(count), 64'd0);
    chk("ovf_empty_valid", 64'(vrf_valid), 64'd0);
    chk("ovf_still_set", 64'(overflow), 64'd1);

    // Reset mid-run
    vrf_ready = 1'b0;
    for (int k = 0; k < 5; k++) push_vec(64'h4000 + 64'(k), 32'(k));
    chk("pre_rst_count", 64'(count), 64'd5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_vrf_valid", 64'(vrf_valid), 64'd0);
    chk("rst_sca_valid", 64'(sca_valid), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_stall", 64'(issue_stall), 64'd0);
    push_vec(64'h77, 32'h7);
    chk("post_rst_valid", 64'(vrf_valid), 64'd1);
    chk("post_rst_data", vrf_data, 64'h77);
    chk("post_rst_count", 64'(count), 64'd1);
    vrf_ready = 1'b1;
    cyc();
    chk("post_rst_drain", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
